// File: rtl/ysyx_2022040010_mem_arbiter.sv
// Memory port arbiter: the ICache and the DCache share one burst memory port.
// Round-robin on ties, with no preemption. One fixed-length burst per grant.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no burst in flight; a pending request is latched as owner
// ADDR  | m_req high; waiting for the memory to accept the address
// DATA  | beats flow; the counter tracks accepted or received beats
module ysyx_2022040010_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_gnt,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_wready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              stallreq_for_cache,
    output logic              rw_over
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    logic [CNT_W-1:0] beat_cnt;

    logic grant_d;
    logic in_data;
    logic own_d;
    logic beat;
    logic last_beat;

    // On a tie the master that did not own the previous burst wins.
    assign grant_d   = d_req & (~i_req | (last_owner == OWN_I));

    // Gating with rst keeps a burst aborted by reset from signalling anything.
    assign in_data   = (state == S_DATA) & ~rst;
    assign own_d     = (owner == OWN_D);
    assign beat      = in_data & (m_we ? m_wready : m_rvalid);
    assign last_beat = beat & (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            beat_cnt   <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req | d_req) begin
                        state <= S_ADDR;
                        m_req <= 1'b1;
                        if (grant_d) begin
                            owner  <= OWN_D;
                            m_we   <= d_we;
                            m_addr <= d_addr;
                        end else begin
                            owner  <= OWN_I;
                            m_we   <= 1'b0;
                            m_addr <= i_addr;
                        end
                    end
                end
                S_ADDR: begin
                    if (m_gnt) begin
                        state    <= S_DATA;
                        m_req    <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state      <= S_IDLE;
                            last_owner <= owner;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is steered combinationally; only the owner sees valid.
    assign i_rvalid = in_data & ~own_d & m_rvalid;
    assign d_rvalid = in_data &  own_d & ~m_we & m_rvalid;
    assign d_wnext  = in_data &  own_d &  m_we & m_wready;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    assign m_wdata  = (own_d & m_we & (state != S_IDLE)) ? d_wdata : '0;

    assign i_done   = last_beat & ~own_d;
    assign d_done   = last_beat &  own_d;
    assign rw_over  = last_beat;

    assign stallreq_for_cache = (i_req | d_req) & ~rw_over & ~rst;

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// Randomized bench for the memory arbiter: a memory/master model drives traffic
// and queues the expected beats; a separate monitor checks every DUT beat.
module tb_ysyx_2022040010_mem_arbiter;

    localparam int BL   = 4;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr;
    logic [63:0] d_wdata;
    logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
    logic [63:0] i_rdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_wready, m_rvalid;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic        stallreq_for_cache, rw_over;

    ysyx_2022040010_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_gnt(m_gnt), .m_wdata(m_wdata),
        .m_wready(m_wready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stallreq_for_cache(stallreq_for_cache), .rw_over(rw_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        owner;   // 0 = ICache, 1 = DCache
        logic        wr;
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [63:0] rd_pat(input logic [31:0] a, input int k);
        return {a ^ 32'h5a5a_0000, a + 32'(k) * 32'h0101_0101};
    endfunction

    function automatic logic [63:0] wr_pat(input logic [31:0] a, input int k);
        return {~a, a + 32'(k * 7 + 1)};
    endfunction

    function automatic logic [31:0] rand_line();
        logic [31:0] r;
        r = $urandom;
        return {r[31:5], 5'b0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    int   mon_n;
    logic mon_last;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_quiet",
                  {56'd0, i_rvalid, d_rvalid, d_wnext, i_done, d_done, rw_over, stallreq_for_cache, m_req},
                  64'd0);
        end else begin
            mon_n    = int'(i_rvalid) + int'(d_rvalid) + int'(d_wnext);
            mon_last = 1'b0;
            if (mon_n > 1) begin
                check("beat_onehot", 64'(mon_n), 64'd1);
            end else if (mon_n == 1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {61'd0, i_rvalid, d_rvalid, d_wnext}, 64'd0);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_last = mon_e.last;
                    check("beat_dest", {61'd0, i_rvalid, d_rvalid, d_wnext},
                          !mon_e.owner ? 64'd4 : (mon_e.wr ? 64'd1 : 64'd2));
                    if (!mon_e.wr)
                        check("rdata", mon_e.owner ? d_rdata : i_rdata, mon_e.data);
                    check("done_flags", {61'd0, i_done, d_done, rw_over},
                          {61'd0, mon_e.last & ~mon_e.owner, mon_e.last & mon_e.owner, mon_e.last});
                end
            end else begin
                check("quiet_done", {61'd0, i_done, d_done, rw_over}, 64'd0);
            end
            check("stall", 64'(stallreq_for_cache), 64'((i_req | d_req) & ~mon_last));
        end
    end

    // ---------------- memory / master model ----------------
    int          phase;        // 0 no burst, 1 waiting for address accept, 2 beats
    logic        cur_owner, cur_we, last_owner, exp_owner;
    logic [31:0] cur_addr;
    int          beats, gnt_hold, i_wait, d_wait, i_age, d_age;
    logic        prev_idle, prev_i, prev_d, started, start_none;
    logic        fin_i, fin_d, plan_rst, rst_done, stop_new, timed_out, beat_now;
    exp_t        tmp;

    initial begin
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_wready = 0; m_rvalid = 0; m_rdata = '0;
        phase = 0; beats = 0; gnt_hold = 0; i_wait = 0; d_wait = 0; i_age = 0; d_age = 0;
        cur_owner = 0; cur_we = 0; cur_addr = '0; last_owner = 0;
        prev_idle = 0; prev_i = 0; prev_d = 0;
        plan_rst = 0; rst_done = 0; stop_new = 0; timed_out = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Both masters request in the first cycle after reset: D must win.
        i_req = 1; i_addr = rand_line();
        d_req = 1; d_addr = rand_line(); d_we = 1'($urandom_range(0, 1));
        d_wdata = wr_pat(d_addr, 0);

        for (int cyc = 0; cyc < NCYC + 800; cyc++) begin
            @(negedge clk);
            fin_i = 0; fin_d = 0;
            if (rst) begin
                phase = 0; last_owner = 0; prev_idle = 0;
                exp_q.delete();
            end else begin
                start_none = (phase == 0);
                started    = 0;
                if (phase == 0) begin
                    check("m_req_timing", 64'(m_req), 64'(prev_idle & (prev_i | prev_d)));
                    if (m_req && prev_idle) begin
                        exp_owner = (prev_i && prev_d) ? ~last_owner : prev_d;
                        check("grant_addr", m_addr, exp_owner ? d_addr : i_addr);
                        check("grant_we", 64'(m_we), 64'(exp_owner ? d_we : 1'b0));
                        cur_owner = exp_owner;
                        cur_we    = exp_owner ? d_we : 1'b0;
                        cur_addr  = exp_owner ? d_addr : i_addr;
                        phase     = 1;
                        started   = 1;
                        gnt_hold  = ($urandom_range(0, 5) == 0) ? 10 : 0;
                    end
                end else if (phase == 1) begin
                    check("m_req_held", 64'(m_req), 64'd1);
                    check("m_addr_stable", m_addr, cur_addr);
                end
                if (phase == 1 && m_gnt && m_req) begin
                    phase = 2;
                    beats = 0;
                    for (int k = 0; k < BL; k++) begin
                        tmp.owner = cur_owner;
                        tmp.wr    = cur_we;
                        tmp.data  = cur_we ? wr_pat(cur_addr, k) : rd_pat(cur_addr, k);
                        tmp.last  = (k == BL - 1);
                        exp_q.push_back(tmp);
                    end
                end else if (phase == 2) begin
                    beat_now = cur_we ? m_wready : m_rvalid;
                    if (beat_now) begin
                        if (cur_we) begin
                            check("m_wdata", m_wdata, wr_pat(cur_addr, beats));
                            check("d_wnext", 64'(d_wnext), 64'd1);
                        end
                        beats++;
                        if (beats == BL) begin
                            phase      = 0;
                            last_owner = cur_owner;
                            if (cur_owner) fin_d = 1; else fin_i = 1;
                        end
                    end else if (cur_we) begin
                        check("d_wnext_idle", 64'(d_wnext), 64'd0);
                    end
                end
                prev_idle = start_none & ~started;
                prev_i    = i_req;
                prev_d    = d_req;
                if (!rst_done && cyc >= 1000 && phase == 2 && !cur_we && beats == 1) begin
                    plan_rst = 1;
                    rst_done = 1;
                end
            end

            i_age = i_req ? i_age + 1 : 0;
            d_age = d_req ? d_age + 1 : 0;
            if (i_age > 400 || d_age > 400) begin
                checks++; failures++; timed_out = 1;
                $display("FAIL req_timeout actual=%0d/%0d required<=400 t=%0t", i_age, d_age, $time);
                break;
            end
            stop_new = (cyc >= NCYC);
            if (stop_new && !i_req && !d_req && phase == 0) break;

            @(posedge clk);
            #1;
            rst = plan_rst;
            // ICache master: drop after completion, optionally re-request at once.
            if (fin_i) begin i_req = 0; i_age = 0; i_wait = $urandom_range(0, 4); end
            if (!i_req && !stop_new) begin
                if (i_wait == 0) begin i_req = 1; i_addr = rand_line(); end
                else i_wait--;
            end
            if (fin_d) begin d_req = 0; d_age = 0; d_wait = $urandom_range(0, 4); end
            if (!d_req && !stop_new) begin
                if (d_wait == 0) begin
                    d_req = 1; d_addr = rand_line(); d_we = 1'($urandom_range(0, 1));
                end else d_wait--;
            end
            d_wdata = (phase == 2 && cur_owner && cur_we) ? wr_pat(d_addr, beats) : wr_pat(d_addr, 0);

            // Memory side, with junk handshakes whenever no beat is due.
            if (phase == 1 && gnt_hold > 0) begin
                m_gnt = 0;
                gnt_hold--;
            end else begin
                m_gnt = ($urandom_range(0, 2) == 0);
            end
            if (phase == 2 && !cur_we) begin
                m_rvalid = 1'($urandom_range(0, 1));
                m_rdata  = m_rvalid ? rd_pat(cur_addr, beats) : {$urandom, $urandom};
            end else begin
                m_rvalid = ($urandom_range(0, 3) == 0);
                m_rdata  = {$urandom, $urandom};
            end
            m_wready = (phase == 2 && cur_we) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            if (plan_rst) begin
                m_rvalid = 1;
                m_rdata  = rd_pat(cur_addr, 1);
                plan_rst = 0;
            end
        end

        if (!timed_out) begin
            check("drained", 64'({i_req, d_req, 1'(phase != 0)}), 64'd0);
            repeat (2) @(negedge clk);
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("reset_exercised", 64'(rst_done), 64'd1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
